rom_stream_ctrl: RTL and testbench
==================================

# rom_stream_ctrl

Sequencer that reads a contiguous run of words from the weight ROM (`rom_memory`) and streams them to the downstream weight-loading logic over a valid/ready interface. It owns the ROM's address and read-enable inputs, so the ROM becomes a burst source started by a single pulse. A one-entry output register decouples the ROM's combinational read path from downstream back-pressure. Sustained throughput is one word per cycle.

## Interface
Parameters:
- `MEMORY_WIDTH`, 72, ROM word width.
- `ADDRS_WIDTH`, 8, ROM address width.
- `CNT_WIDTH`, `ADDRS_WIDTH+1`, width of the burst length field; allows a full-ROM burst.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  burst request; sampled only in IDLE.
- `base_addr_i`  in  ADDRS_WIDTH  first ROM address; latched on an accepted start.
- `num_words_i`  in  CNT_WIDTH  burst length in words; latched on an accepted start.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at burst completion.
- `addrs_mem_o`  out  ADDRS_WIDTH  to ROM `addrs_mem_i`.
- `rd_mem_ld_o`  out  1  to ROM `rd_mem_ld_i`.
- `mem_data_i`  in  MEMORY_WIDTH  from ROM `mem_data_o`; combinational in the same cycle.
- `data_o`  out  MEMORY_WIDTH  streamed word.
- `valid_o`  out  1  `data_o` holds a valid word.
- `ready_i`  in  1  downstream accepts; a beat transfers when `valid_o & ready_i`.

## Operation
- Reset value of all outputs is 0. Internal state resets to IDLE, with the address and remaining-count registers cleared.
- **IDLE:**
  - `start_i=1` latches `base_addr_i` and `num_words_i` and moves to READ.
  - If `num_words_i==0`, the block instead moves to DONE directly; no ROM access takes place.
- **READ:**
  - A fetch happens in any cycle where the output register is free, meaning `valid_o==0` or `ready_i==1`, and remaining > 0.
  - On a fetch: `rd_mem_ld_o=1` and `addrs_mem_o`=current address. `mem_data_i` is captured into `data_o`, `valid_o` is set at the next edge, the address increments, and remaining decrements.
  - In all other cycles `rd_mem_ld_o=0`. `addrs_mem_o` holds the current address.
  - When remaining reaches 0, move to DRAIN.
- **DRAIN:** wait until the output register empties (`valid_o==0`, or a handshake occurs this cycle), then move to DONE.
- **DONE:** `done_o=1` for exactly one cycle, then return to IDLE.
- **Address arithmetic:** the address increments modulo 2^ADDRS_WIDTH, so a burst past the top address wraps to 0. No error is flagged.
- **Start while busy:** `start_i` is ignored outside IDLE and is not queued.
- **Reset mid-burst:** immediate return to IDLE with `valid_o=0`. The word held in the output register is discarded and no `done_o` is produced.
- **Output stability:** `data_o` is held stable while `valid_o & ~ready_i`.

## Timing
- Cycle 0: edge at which `start_i` is sampled high.
- Cycle 1: READ; first fetch at `base_addr_i`.
- Cycle 2: `valid_o=1` with word[base].
- With `ready_i` held high, N words appear on cycles 2..N+1.
- `done_o` is asserted in cycle N+2, which is also the first cycle `valid_o` is low again; the block is in IDLE at cycle N+3.
- With `ready_i` low, no fetch occurs and no word is lost or duplicated.
- `num_words_i==0`: `done_o` in cycle 1; `rd_mem_ld_o` stays 0 throughout.
- The earliest next accepted `start_i` is the cycle after `done_o`.

## Configuration
- Macro `ROM_STREAM_ZERO_SKIP_EN`.
- **Defined:**
  - A fetched word equal to all zeros is not loaded into the output register. It still consumes one address and one count.
  - A registered output `skip_cnt_o[CNT_WIDTH-1:0]` counts such words; it is cleared on reset and on every accepted start.
  - If trailing words are skipped, DRAIN/DONE proceed as normal.
- **Undefined:** every fetched word is streamed and `skip_cnt_o` does not exist.

## Test plan
- **Basic burst:** ROM word k = k+1, base=4, num=3, `ready_i`=1 → `data_o` = 5, 6, 7 on cycles 2–4; `done_o` pulses on cycle 5; `rd_mem_ld_o` is high on cycles 1–3 only.
- **Back-pressure:** same burst with `ready_i` low on cycles 3–5 → word 6 is held stable on `data_o` for those cycles; `rd_mem_ld_o` stays 0 while stalled; exactly 3 handshakes occur, in order.
- **Wrap-around:** ADDRS_WIDTH=8, base=254, num=4 → addresses 254, 255, 0, 1; `done_o` after the 4th handshake.
- **Zero-length and ignored start:** num=0 → `done_o` on cycle 1, `valid_o` never set. A `start_i` pulse during an active burst → no effect on address sequence or count.
- **Reset mid-burst:** `rst_n_i` low while `valid_o`=1 → all outputs 0 asynchronously. A new burst after reset starts cleanly at its own base.
- **Zero-skip (macro defined):** words 9, 0, 0, 3 at base 0, num=4 → stream is 9, 3; `skip_cnt_o`=2; `done_o` pulses once.

Source files
------------

// File: rtl/rom_stream_ctrl.sv
// Streams a ROM burst to valid/ready: word[base] valid 2 cycles after start, then one word/cycle; fetch stalls while output is held.
// Optional `ROM_STREAM_ZERO_SKIP_EN drops all-zero words and counts them on skip_cnt_o.
module rom_stream_ctrl #(
  parameter int MEMORY_WIDTH = 72,
  parameter int ADDRS_WIDTH  = 8,
  parameter int CNT_WIDTH    = ADDRS_WIDTH + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [ADDRS_WIDTH-1:0]  base_addr_i,
  input  logic [CNT_WIDTH-1:0]    num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDRS_WIDTH-1:0]  addrs_mem_o,
  output logic                    rd_mem_ld_o,
  input  logic [MEMORY_WIDTH-1:0] mem_data_i,
  output logic [MEMORY_WIDTH-1:0] data_o,
  output logic                    valid_o,
`ifdef ROM_STREAM_ZERO_SKIP_EN
  output logic [CNT_WIDTH-1:0]    skip_cnt_o,
`endif
  input  logic                    ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDRS_WIDTH-1:0]  r_addr;
  logic [CNT_WIDTH-1:0]    r_remaining;
  logic [MEMORY_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;
`ifdef ROM_STREAM_ZERO_SKIP_EN
  logic [CNT_WIDTH-1:0]    r_skip_cnt;
`endif

  logic w_out_free;
  logic w_fetch;
  logic w_last_fetch;
  logic w_load;

  // The ROM read is combinational, so the fetch strobe must follow ready_i in the same cycle.
  assign w_out_free   = ~r_valid | ready_i;
  assign w_fetch      = (r_state == S_READ) && (r_remaining != '0) && w_out_free;
  assign w_last_fetch = w_fetch && (r_remaining == CNT_WIDTH'(1));
`ifdef ROM_STREAM_ZERO_SKIP_EN
  assign w_load       = w_fetch && (mem_data_i != '0);
`else
  assign w_load       = w_fetch;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef ROM_STREAM_ZERO_SKIP_EN
      r_skip_cnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_valid && ready_i)
        r_valid <= 1'b0;
      if (w_load) begin
        r_data  <= mem_data_i;
        r_valid <= 1'b1;
      end
      if (w_fetch) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
`ifdef ROM_STREAM_ZERO_SKIP_EN
      if (w_fetch && !w_load)
        r_skip_cnt <= r_skip_cnt + 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr      <= base_addr_i;
            r_remaining <= num_words_i;
            r_busy      <= 1'b1;
`ifdef ROM_STREAM_ZERO_SKIP_EN
            r_skip_cnt  <= '0;
`endif
            if (num_words_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_last_fetch)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_free) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign addrs_mem_o = r_addr;
  assign rd_mem_ld_o = w_fetch;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
`ifdef ROM_STREAM_ZERO_SKIP_EN
  assign skip_cnt_o  = r_skip_cnt;
`endif

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Directed bench for rom_stream_ctrl with a behavioural ROM (word k = k+1).
module tb_rom_stream_ctrl;

  localparam int MW = 72;
  localparam int AW = 8;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [CW-1:0] num;
  logic          busy, done, rd, valid, ready;
  logic [AW-1:0] addr;
  logic [MW-1:0] mem_data, data;
`ifdef ROM_STREAM_ZERO_SKIP_EN
  logic [CW-1:0] skip_cnt;
`endif

  logic [MW-1:0] rom [256];
  assign mem_data = rom[addr];

  always #5 clk = ~clk;

  rom_stream_ctrl #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .base_addr_i (base),
    .num_words_i (num),
    .busy_o      (busy),
    .done_o      (done),
    .addrs_mem_o (addr),
    .rd_mem_ld_o (rd),
    .mem_data_i  (mem_data),
    .data_o      (data),
    .valid_o     (valid),
`ifdef ROM_STREAM_ZERO_SKIP_EN
    .skip_cnt_o  (skip_cnt),
`endif
    .ready_i     (ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [MW-1:0] hs_q [$];
  logic [MW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then sample outputs; records handshakes.
  task automatic cyc(input logic st, input logic rdy);
    @(negedge clk);
    start = st;
    ready = rdy;
    #1;
    if (valid && ready) hs_q.push_back(data);
    if (done) n_done++;
  endtask

  task automatic chk_stream(input string tag);
    logic [MW-1:0] got;
    chk({tag, "_len"}, MW'(hs_q.size()), MW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < hs_q.size()) ? hs_q[i] : 'x;
      chk(tag, got, exp_q[i]);
    end
  endtask

  task automatic new_test();
    hs_q.delete();
    exp_q.delete();
    n_done = 0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = MW'(k + 1);
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; base = '0; num = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd", rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic burst: base 4, num 3, ready always high.
    new_test(); base = 8'd4; num = 9'd3;
    cyc(1, 1); chk("b0_busy", busy, 0);
    cyc(0, 1); chk("b1_rd", rd, 1); chk("b1_addr", addr, 4); chk("b1_valid", valid, 0); chk("b1_busy", busy, 1);
    cyc(0, 1); chk("b2_valid", valid, 1); chk("b2_data", data, 5); chk("b2_rd", rd, 1); chk("b2_addr", addr, 5);
    cyc(0, 1); chk("b3_data", data, 6); chk("b3_rd", rd, 1); chk("b3_addr", addr, 6);
    cyc(0, 1); chk("b4_data", data, 7); chk("b4_rd", rd, 0); chk("b4_done", done, 0);
    cyc(0, 1); chk("b5_done", done, 1); chk("b5_valid", valid, 0); chk("b5_busy", busy, 1); chk("b5_rd", rd, 0);
    cyc(0, 1); chk("b6_done", done, 0); chk("b6_busy", busy, 0);
    exp_q = '{72'd5, 72'd6, 72'd7}; chk_stream("basic_stream");

    // Back-pressure on cycles 3..5.
    new_test(); base = 8'd4; num = 9'd3;
    cyc(1, 1);
    cyc(0, 1); chk("bp1_addr", addr, 4);
    cyc(0, 1); chk("bp2_data", data, 5);
    for (int c = 3; c <= 5; c++) begin
      cyc(0, 0);
      chk("bp_hold_data", data, 6); chk("bp_hold_valid", valid, 1); chk("bp_hold_rd", rd, 0);
    end
    cyc(0, 1); chk("bp6_rd", rd, 1); chk("bp6_addr", addr, 6);
    cyc(0, 1); chk("bp7_data", data, 7); chk("bp7_rd", rd, 0);
    cyc(0, 1); chk("bp8_done", done, 1);
    exp_q = '{72'd5, 72'd6, 72'd7}; chk_stream("bp_stream");
    chk("bp_ndone", MW'(n_done), 1);

    // Wrap-around: 254, 255, 0, 1.
    new_test(); base = 8'd254; num = 9'd4;
    cyc(1, 1);
    cyc(0, 1); chk("w1_addr", addr, 254);
    cyc(0, 1); chk("w2_addr", addr, 255);
    cyc(0, 1); chk("w3_addr", addr, 0);
    cyc(0, 1); chk("w4_addr", addr, 1); chk("w4_rd", rd, 1);
    cyc(0, 1); chk("w5_done", done, 0); chk("w5_rd", rd, 0);
    cyc(0, 1); chk("w6_done", done, 1);
    exp_q = '{72'd255, 72'd256, 72'd1, 72'd2}; chk_stream("wrap_stream");

    // Zero-length burst.
    new_test(); base = 8'd10; num = 9'd0;
    cyc(1, 1);
    cyc(0, 1); chk("z1_done", done, 1); chk("z1_valid", valid, 0); chk("z1_rd", rd, 0); chk("z1_busy", busy, 1);
    cyc(0, 1); chk("z2_done", done, 0); chk("z2_busy", busy, 0); chk("z2_valid", valid, 0);
    chk("z_nhs", MW'(hs_q.size()), 0);

    // Start pulse during an active burst is ignored.
    new_test(); base = 8'd4; num = 9'd3;
    cyc(1, 1);
    cyc(0, 1); chk("i1_addr", addr, 4);
    base = 8'd100; num = 9'd9;
    cyc(1, 1); chk("i2_addr", addr, 5);
    cyc(0, 1); chk("i3_addr", addr, 6);
    cyc(0, 1); chk("i4_rd", rd, 0);
    cyc(0, 1); chk("i5_done", done, 1);
    cyc(0, 1); chk("i6_busy", busy, 0);
    exp_q = '{72'd5, 72'd6, 72'd7}; chk_stream("ign_stream");
    chk("ign_ndone", MW'(n_done), 1);

    // Reset mid-burst, then a clean burst at base 20.
    new_test(); base = 8'd4; num = 9'd3;
    cyc(1, 1);
    cyc(0, 1);
    cyc(0, 0); chk("r2_valid", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ra_valid", valid, 0); chk("ra_busy", busy, 0); chk("ra_rd", rd, 0);
    chk("ra_addr", addr, 0); chk("ra_data", data, 0); chk("ra_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    new_test(); base = 8'd20; num = 9'd2;
    cyc(1, 1);
    cyc(0, 1); chk("p1_addr", addr, 20); chk("p1_rd", rd, 1);
    cyc(0, 1); chk("p2_data", data, 21); chk("p2_addr", addr, 21);
    cyc(0, 1); chk("p3_data", data, 22); chk("p3_rd", rd, 0);
    cyc(0, 1); chk("p4_done", done, 1);
    exp_q = '{72'd21, 72'd22}; chk_stream("post_rst_stream");

`ifdef ROM_STREAM_ZERO_SKIP_EN
    // Zero-skip: words 9,0,0,3 stream as 9,3.
    rom[0] = 72'd9; rom[1] = 72'd0; rom[2] = 72'd0; rom[3] = 72'd3;
    new_test(); base = 8'd0; num = 9'd4;
    cyc(1, 1);
    for (int c = 1; c <= 6; c++) cyc(0, 1);
    exp_q = '{72'd9, 72'd3}; chk_stream("skip_stream");
    chk("skip_cnt", skip_cnt, 2);
    chk("skip_ndone", MW'(n_done), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
